// File: rtl/ifu_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned REG_WIDTH  = 64;
  localparam int unsigned INST_WIDTH = 32;
  localparam logic [63:0] RST_PC_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    TRAP
  } state_t;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [REG_WIDTH-1:0]  pc;
    logic                  misalign;
  } fetch_entry_t;

  // Memory returns a doubleword; pc[2] picks the upper or lower word.
  function automatic logic [INST_WIDTH-1:0] select_inst(input logic [REG_WIDTH-1:0] rdata,
                                                        input logic upper);
    return upper ? rdata[63:32] : rdata[31:0];
  endfunction

endpackage

// File: rtl/ifu_fifo2.sv
// Two-entry in-order queue of fetched instructions with flush.
module ifu_fifo2
  import ifu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic [1:0]   cnt;
  logic         do_pop;

  assign do_pop = pop && (cnt != 2'd0);
  assign head   = slot0;
  assign count  = cnt;

  // Flush discards everything; a push in the same cycle lands in the emptied head slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= '0;
    end else if (flush) begin
      cnt <= push ? 2'd1 : 2'd0;
      if (push) slot0 <= push_data;
    end else begin
      case ({push, do_pop})
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b10: begin
          if (cnt == 2'd0) slot0 <= push_data;
          else             slot1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues doubleword reads, queues
// fetched instructions for decode and handles redirects.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [63:0] RST_PC = RST_PC_DEFAULT,
  parameter int unsigned XLEN   = REG_WIDTH,
  parameter int unsigned ILEN   = INST_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_misalign
);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_addr;
  logic            pending;
  logic            squash;

  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            push;
  logic            pop;
  logic [1:0]      count;
  logic [1:0]      count_after;
  logic            deq;
  logic            issue;
  logic            req;
  logic            resp;
  logic            target_misaligned;
  logic [XLEN-1:0] pc_addr;

  ifu_fifo2 u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  assign inst_valid    = (count != 2'd0);
  assign inst          = head.inst;
  assign inst_pc       = head.pc;
  assign inst_misalign = head.misalign;

  assign deq               = inst_valid && inst_ready;
  assign count_after       = count - {1'b0, deq};
  assign pc_addr           = {pc[XLEN-1:3], 3'b000};
  assign target_misaligned = (redirect_pc[1:0] != 2'b00);

  // An outstanding request keeps its own address so a redirect cannot disturb it.
  assign issue    = (state == RUN) && !pending && (count_after < 2'd2);
  assign req      = pending || issue;
  assign resp     = mem_rvalid && req;
  assign mem_req  = req && !rst;
  assign mem_addr = rst ? '0 : (pending ? req_addr : pc_addr);

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    pop       = deq && !redirect_valid;
    if (redirect_valid) begin
      if (target_misaligned) begin
        push      = 1'b1;
        push_data = '{inst: '0, pc: redirect_pc, misalign: 1'b1};
      end
    end else if (resp && !squash) begin
      push      = 1'b1;
      push_data = '{inst: select_inst(mem_rdata, pc[2]), pc: pc, misalign: 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RST_PC;
      req_addr <= '0;
      pending  <= 1'b0;
      squash   <= 1'b0;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      state <= target_misaligned ? TRAP : RUN;
      if (req && !mem_rvalid) begin
        pending <= 1'b1;
        squash  <= 1'b1;
        if (!pending) req_addr <= pc_addr;
      end else begin
        pending <= 1'b0;
        squash  <= 1'b0;
      end
    end else begin
      if (state == IDLE) state <= RUN;
      if (resp) begin
        pending <= 1'b0;
        squash  <= 1'b0;
        if (!squash) pc <= pc + XLEN'(4);
      end else if (issue) begin
        pending  <= 1'b1;
        req_addr <= pc_addr;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: directed scenarios plus randomized traffic.
module tb_ifu_fetch;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_misalign;
  logic        stray = 1'b0;
  logic        saw_rst = 1'b0;

  int   lat = 0;
  int   waitcnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  ifu_fetch #(.RST_PC(RST_PC), .XLEN(64), .ILEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_misalign (inst_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == RST_PC) return 64'h00100093_00000413;
    return {a[31:0] ^ 32'h9E37_79B9, a[31:0] + a[63:32] + 32'h1357_9BDF};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] p);
    logic [63:0] w;
    w = mem_word({p[63:3], 3'b000});
    return p[2] ? w[63:32] : w[31:0];
  endfunction

  // Memory: answers after 'lat' cycles of a held request; 'stray' forces rvalid.
  assign mem_rdata  = mem_word(mem_addr);
  assign mem_rvalid = (mem_req && (waitcnt >= lat)) || stray;
  always @(posedge clk) waitcnt <= (mem_req && !mem_rvalid) ? waitcnt + 1 : 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic [63:0] start);
    logic [63:0] p;
    sb.delete();
    p = start;
    for (int unsigned i = 0; i < 256; i++) begin
      sb.push_back('{pc: p, inst: exp_inst(p), mis: 1'b0});
      p = p + 64'd4;
    end
  endtask

  task automatic start_redirect(input logic [63:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    if (t[1:0] != 2'b00) begin
      sb.delete();
      sb.push_back('{pc: t, inst: 32'h0, mis: 1'b1});
    end else begin
      push_stream(t);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    stray          = 1'b0;
    push_stream(RST_PC);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!inst_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!inst_valid) timeout(nm);
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req) timeout(nm);
  endtask

  initial forever begin
    @(posedge rst);
    saw_rst = 1'b1;
  end

  // Monitor: scoreboard pops on every accepted handshake, plus protocol checks.
  initial begin
    logic        prev_hold;
    logic [63:0] prev_addr;
    logic        prev_head;
    logic [63:0] prev_pc;
    logic [31:0] prev_inst;
    logic        prev_mis;
    logic        trap_m;
    exp_t        e;
    prev_hold = 1'b0;
    prev_head = 1'b0;
    trap_m    = 1'b0;
    prev_addr = '0;
    prev_pc   = '0;
    prev_inst = '0;
    prev_mis  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || saw_rst) begin
        saw_rst   = 1'b0;
        prev_hold = 1'b0;
        prev_head = 1'b0;
        trap_m    = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("req_hold", {63'd0, mem_req}, 64'd1);
          chk("addr_hold", mem_addr, prev_addr);
        end
        if (prev_head) begin
          chk("head_valid_hold", {63'd0, inst_valid}, 64'd1);
          chk("head_pc_hold", inst_pc, prev_pc);
          chk("head_inst_hold", {32'd0, inst}, {32'd0, prev_inst});
          chk("head_mis_hold", {63'd0, inst_misalign}, {63'd0, prev_mis});
        end
        if (trap_m && lat == 0) chk("trap_no_req", {63'd0, mem_req}, 64'd0);
        if (mem_req) chk("addr_aligned", {61'd0, mem_addr[2:0]}, 64'd0);
        if (inst_valid && inst_ready && !redirect_valid) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("sb_pc", inst_pc, e.pc);
            chk("sb_inst", {32'd0, inst}, {32'd0, e.inst});
            chk("sb_misalign", {63'd0, inst_misalign}, {63'd0, e.mis});
          end
        end
        prev_hold = mem_req && !mem_rvalid;
        prev_addr = mem_addr;
        prev_head = inst_valid && !inst_ready && !redirect_valid;
        prev_pc   = inst_pc;
        prev_inst = inst;
        prev_mis  = inst_misalign;
        if (redirect_valid) trap_m = (redirect_pc[1:0] != 2'b00);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [63:0] t;

    // 1: reset values and the first two instructions from RST_PC
    #1 rst = 1'b1;
    #2;
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_misalign", {63'd0, inst_misalign}, 64'd0);
    lat = 0;
    inst_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("t1_idle_no_req", {63'd0, mem_req}, 64'd0);
    wait_req("t1_first_req");
    chk("t1_first_addr", mem_addr, 64'h8000_0000);
    @(negedge clk);
    chk("t1_inst0", {32'd0, inst}, 64'h0000_0413);
    chk("t1_pc0", inst_pc, 64'h8000_0000);
    @(negedge clk);
    chk("t1_inst1", {32'd0, inst}, 64'h0010_0093);
    chk("t1_pc1", inst_pc, 64'h8000_0004);
    chk("t1_next_addr", mem_addr, 64'h8000_0008);
    tick();

    // 2: decode stalled from reset
    inst_ready = 1'b0;
    do_reset();
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_req && mem_rvalid) n++;
    end
    chk("t2_fetch_count", 64'(n), 64'd2);
    chk("t2_no_req", {63'd0, mem_req}, 64'd0);
    chk("t2_head_inst", {32'd0, inst}, 64'h0000_0413);
    chk("t2_head_pc", inst_pc, 64'h8000_0000);
    tick();
    inst_ready = 1'b1;
    @(negedge clk);
    chk("t2_resume_req", {63'd0, mem_req}, 64'd1);
    chk("t2_resume_addr", mem_addr, 64'h8000_0008);
    @(negedge clk);
    chk("t2_second_pc", inst_pc, 64'h8000_0004);
    tick();

    // 3: redirect with a request pending on a 2-cycle memory
    lat = 2;
    do_reset();
    n = 0;
    @(negedge clk);
    while (!(mem_req && !mem_rvalid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(mem_req && !mem_rvalid)) timeout("t3_pending");
    tick();
    start_redirect(64'h8000_0100);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_stale_rvalid", {63'd0, mem_rvalid}, 64'd1);
    chk("t3_stale_addr", mem_addr, 64'h8000_0000);
    @(negedge clk);
    chk("t3_new_req", {63'd0, mem_req}, 64'd1);
    chk("t3_new_addr", mem_addr, 64'h8000_0100);
    wait_valid("t3_valid");
    chk("t3_first_pc", inst_pc, 64'h8000_0100);
    tick();

    // 4: misaligned redirect, trap, then recovery
    lat = 0;
    do_reset();
    wait_valid("t4_warm");
    tick();
    start_redirect(64'h8000_0102);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_mark_valid", {63'd0, inst_valid}, 64'd1);
    chk("t4_mark_mis", {63'd0, inst_misalign}, 64'd1);
    chk("t4_mark_inst", {32'd0, inst}, 64'd0);
    chk("t4_mark_pc", inst_pc, 64'h8000_0102);
    repeat (10) @(negedge clk);
    chk("t4_trap_req", {63'd0, mem_req}, 64'd0);
    chk("t4_trap_valid", {63'd0, inst_valid}, 64'd0);
    tick();
    start_redirect(64'h8000_0200);
    tick();
    redirect_valid = 1'b0;
    wait_req("t4_resume_req");
    chk("t4_resume_addr", mem_addr, 64'h8000_0200);
    wait_valid("t4_resume_valid");
    chk("t4_resume_pc", inst_pc, 64'h8000_0200);
    tick();

    // 5: asynchronous reset pulse while a request is outstanding
    lat = 2;
    do_reset();
    n = 0;
    @(negedge clk);
    while (!(mem_req && !mem_rvalid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(mem_req && !mem_rvalid)) timeout("t5_pending");
    #2 rst = 1'b1;
    push_stream(RST_PC);
    #1;
    chk("t5_req_zero", {63'd0, mem_req}, 64'd0);
    chk("t5_addr_zero", mem_addr, 64'd0);
    chk("t5_valid_zero", {63'd0, inst_valid}, 64'd0);
    chk("t5_inst_zero", {32'd0, inst}, 64'd0);
    chk("t5_pc_zero", inst_pc, 64'd0);
    chk("t5_mis_zero", {63'd0, inst_misalign}, 64'd0);
    #1 rst = 1'b0;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    wait_req("t5_restart_req");
    chk("t5_restart_addr", mem_addr, 64'h8000_0000);
    wait_valid("t5_restart_valid");
    chk("t5_restart_pc", inst_pc, 64'h8000_0000);
    chk("t5_restart_inst", {32'd0, inst}, 64'h0000_0413);
    tick();

    // 6: redirect coinciding with a response and a dequeue
    lat = 0;
    do_reset();
    wait_valid("t6_warm");
    repeat (3) @(negedge clk);
    tick();
    start_redirect(64'h8000_0300);
    @(negedge clk);
    chk("t6_coincide", {63'd0, inst_valid && inst_ready && mem_rvalid}, 64'd1);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t6_flushed", {63'd0, inst_valid}, 64'd0);
    wait_valid("t6_valid");
    chk("t6_first_pc", inst_pc, 64'h8000_0300);
    tick();

    // randomized traffic
    for (int seg = 0; seg < 10; seg++) begin
      lat = int'($urandom_range(0, 2));
      do_reset();
      for (int c = 0; c < 200; c++) begin
        inst_ready = ($urandom_range(0, 3) != 0);
        stray      = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 15) == 0) begin
          case ($urandom_range(0, 7))
            5, 6:    t = (RST_PC + 64'($urandom_range(0, 4095)) * 64'd4) | 64'($urandom_range(1, 3));
            7:       t = 64'hFFFF_FFFF_FFFF_FFF8;
            default: t = RST_PC + 64'($urandom_range(0, 4095)) * 64'd4;
          endcase
          start_redirect(t);
        end else begin
          redirect_valid = 1'b0;
        end
        tick();
      end
      redirect_valid = 1'b0;
      stray          = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
